sync_correlator: RTL
====================

// Module: sync_correlator
// PURPOSE
//  Receive access-code correlator in front of the bit-processing chain. Runs in clk_6M and takes demodulated rxbit at the p_1us bit strobe.
//  Slides a 64-bit window over the received bits and compares it with the expected sync word, counting bit errors.
//  On an acceptable match it issues rx_trailer_st_p and, 4 bits later, rx_header_st_p; header/payload decode is timed from these pulses.
//  Bounds each search with a window counter and reports a timeout when no match occurs.
// PARAMETERS
//  SW_LEN       64  sync word length in bits
//  TRAILER_LEN  4   trailer bits counted between the sync match and header start
//  WIN_W        12  width of the search-window counter and of regi_search_win
// PORTS
//  clk_6M           in   1       6 MHz system clock
//  rstz             in   1       asynchronous reset, active-high (1 = reset)
//  p_1us            in   1       one-cycle bit strobe; rxbit is valid in this cycle
//  rxbit            in   1       demodulated received bit, LSB of the air order first
//  search_start_p   in   1       one-cycle pulse: begin a new correlation search
//  search_abort     in   1       level: force the block to IDLE
//  regi_syncword    in   64      expected sync word; bit 0 is received first
//  regi_corr_thresh in   7       maximum bit errors accepted, 0..64
//  regi_search_win  in   WIN_W   search length in bit strobes
//  sync_found_p     out  1       one-cycle pulse: sync word matched
//  rx_trailer_st_p  out  1       one-cycle pulse, same cycle as sync_found_p
//  rx_header_st_p   out  1       one-cycle pulse: first header bit arrives on the next p_1us
//  search_timeout_p out  1       one-cycle pulse: window expired without a match
//  sync_errs        out  7       error count of the last match; held until the next match
//  corr_busy        out  1       1 while in SEARCH or TRAILER
// BEHAVIOUR
//  Reset: every output is 0; state is IDLE; shreg, fillcnt, wincnt and trlcnt are 0.
//  State machine (2-bit): IDLE, SEARCH, TRAILER.
//   IDLE -> SEARCH on search_start_p. On entry, clear fillcnt, wincnt and trlcnt; shreg keeps its contents.
//   search_start_p in SEARCH or TRAILER restarts the search with the same clears.
//   search_abort=1 -> IDLE on the next edge with no pulses. Abort wins over a simultaneous start, match or timeout.
//  Bit path (SEARCH only, on a p_1us cycle):
//   nxt = {rxbit, shreg[63:1]}; shreg <= nxt.
//   fillcnt increments and saturates at SW_LEN.
//   wincnt increments and saturates at 2^WIN_W-1.
//   errs = popcount(nxt ^ regi_syncword), combinational, 7 bits, range 0..64.
//  Match: p_1us & SEARCH & (fillcnt+1 >= SW_LEN) & (errs <= regi_corr_thresh).
//   Registered. On the next cycle: sync_found_p=1, rx_trailer_st_p=1, sync_errs=errs, state=TRAILER, trlcnt=0.
//   Latency is exactly 1 clk_6M cycle after the strobe cycle carrying the last sync bit.
//   The fill gate prevents stale shreg bits from a previous search from matching.
//  Timeout: p_1us & SEARCH & no match & (wincnt+1 >= regi_search_win).
//   On the next cycle: search_timeout_p=1, state=IDLE.
//   Match and timeout on the same strobe: the match wins and no timeout pulse is issued.
//   regi_search_win=0 times out on the first strobe unless that strobe matches, which cannot happen since fillcnt < SW_LEN.
//  TRAILER: trlcnt counts p_1us strobes.
//   On the strobe where trlcnt+1 == TRAILER_LEN: rx_header_st_p=1 on the next cycle and state=IDLE.
//   Trailer bit values are not checked.
//  corr_busy = (state != IDLE), registered with the state.
//  p_1us is ignored in IDLE; rxbit does not shift.
//  Register inputs are sampled live. Software changes them only while corr_busy=0.
// TESTING
//  T1: thresh=0, win=200; start, then preamble 4'b0101, exact syncword, 4 trailer bits.
//      -> sync_found_p 1 cycle after the 68th strobe; sync_errs=0; rx_header_st_p 1 cycle after the 72nd strobe.
//  T2: syncword with 3 flipped bits, thresh=6 -> match with sync_errs=3.
//      Same stimulus with thresh=2 -> no match, then timeout.
//  T3: win=100, 100 strobes of a PRBS with no match -> search_timeout_p 1 cycle after the 100th strobe; corr_busy falls.
//  T4: first search leaves a full syncword in shreg; restart and drive 30 bits.
//      -> no match before the 64th new bit (fill gate).
//  T5: assert search_abort during TRAILER -> no rx_header_st_p; IDLE next cycle; corr_busy=0.
//  T6: assert rstz=1 mid-SEARCH for 2 cycles -> all outputs 0 asynchronously; a fresh start behaves as T1.

Source files
------------

// File: rtl/sync_correlator_if.sv
// Bit-stream, register and pulse bundle between the receive front end and the sync correlator.
// The master drives strobe/bit/control and register values; the slave returns the pulses and status.
interface sync_correlator_if #(
  parameter int SW_LEN = 64,
  parameter int WIN_W  = 12
);
  logic              p_1us;
  logic              rxbit;
  logic              search_start_p;
  logic              search_abort;
  logic [SW_LEN-1:0] regi_syncword;
  logic [6:0]        regi_corr_thresh;
  logic [WIN_W-1:0]  regi_search_win;

  logic              sync_found_p;
  logic              rx_trailer_st_p;
  logic              rx_header_st_p;
  logic              search_timeout_p;
  logic [6:0]        sync_errs;
  logic              corr_busy;

  modport master (
    output p_1us, rxbit, search_start_p, search_abort,
           regi_syncword, regi_corr_thresh, regi_search_win,
    input  sync_found_p, rx_trailer_st_p, rx_header_st_p,
           search_timeout_p, sync_errs, corr_busy
  );

  modport slave (
    input  p_1us, rxbit, search_start_p, search_abort,
           regi_syncword, regi_corr_thresh, regi_search_win,
    output sync_found_p, rx_trailer_st_p, rx_header_st_p,
           search_timeout_p, sync_errs, corr_busy
  );
endinterface

// File: rtl/sync_correlator.sv
// Sliding 64-bit access-code correlator: match/timeout/header pulses 1 clk after the deciding p_1us strobe.
// No backpressure; bits arrive at the p_1us strobe and are ignored outside SEARCH.
module sync_correlator #(
  parameter int SW_LEN      = 64,
  parameter int TRAILER_LEN = 4,
  parameter int WIN_W       = 12
) (
  input  logic            clk_6M,
  input  logic            rstz,
  sync_correlator_if.slave bus
);

  localparam int FILL_W = $clog2(SW_LEN + 1);
  localparam int TRL_W  = $clog2(TRAILER_LEN + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEARCH  = 2'd1,
    TRAILER = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SW_LEN-1:0] shreg_q, shreg_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [TRL_W-1:0]  trl_q, trl_d;
  logic              found_q, found_d;
  logic              hdr_q, hdr_d;
  logic              tmo_q, tmo_d;
  logic [6:0]        errs_q, errs_d;

  logic [SW_LEN-1:0] nxt_c;
  logic [SW_LEN-1:0] diff_c;
  logic [6:0]        errs_c;
  logic              fill_ok_c;
  logic              errs_ok_c;
  logic              win_end_c;
  logic              trl_last_c;

  assign nxt_c  = {bus.rxbit, shreg_q[SW_LEN-1:1]};
  assign diff_c = nxt_c ^ bus.regi_syncword;

  always_comb begin
    errs_c = '0;
    for (int i = 0; i < SW_LEN; i++) begin
      errs_c = errs_c + {6'd0, diff_c[i]};
    end
  end

  // Fill gate: a restarted search must shift in a whole new word before any match.
  assign fill_ok_c  = ({1'b0, fill_q} + 1'b1) >= (FILL_W + 1)'(SW_LEN);
  assign errs_ok_c  = errs_c <= bus.regi_corr_thresh;
  assign win_end_c  = ({1'b0, win_q} + 1'b1) >= {1'b0, bus.regi_search_win};
  assign trl_last_c = ({1'b0, trl_q} + 1'b1) == (TRL_W + 1)'(TRAILER_LEN);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    fill_d  = fill_q;
    win_d   = win_q;
    trl_d   = trl_q;
    found_d = 1'b0;
    hdr_d   = 1'b0;
    tmo_d   = 1'b0;
    errs_d  = errs_q;

    if (bus.search_abort) begin
      state_d = IDLE;
    end else if (bus.search_start_p) begin
      state_d = SEARCH;
      fill_d  = '0;
      win_d   = '0;
      trl_d   = '0;
    end else begin
      case (state_q)
        SEARCH: begin
          if (bus.p_1us) begin
            shreg_d = nxt_c;
            if (fill_q != FILL_W'(SW_LEN)) fill_d = fill_q + 1'b1;
            if (win_q != '1)               win_d  = win_q + 1'b1;
            // A match on the window's last strobe suppresses the timeout.
            if (fill_ok_c && errs_ok_c) begin
              found_d = 1'b1;
              errs_d  = errs_c;
              state_d = TRAILER;
              trl_d   = '0;
            end else if (win_end_c) begin
              tmo_d   = 1'b1;
              state_d = IDLE;
            end
          end
        end
        TRAILER: begin
          if (bus.p_1us) begin
            if (trl_last_c) begin
              hdr_d   = 1'b1;
              state_d = IDLE;
            end else begin
              trl_d = trl_q + 1'b1;
            end
          end
        end
        IDLE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_6M or posedge rstz) begin
    if (rstz) begin
      state_q <= IDLE;
      shreg_q <= '0;
      fill_q  <= '0;
      win_q   <= '0;
      trl_q   <= '0;
      found_q <= 1'b0;
      hdr_q   <= 1'b0;
      tmo_q   <= 1'b0;
      errs_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      fill_q  <= fill_d;
      win_q   <= win_d;
      trl_q   <= trl_d;
      found_q <= found_d;
      hdr_q   <= hdr_d;
      tmo_q   <= tmo_d;
      errs_q  <= errs_d;
    end
  end

  assign bus.sync_found_p     = found_q;
  assign bus.rx_trailer_st_p  = found_q;
  assign bus.rx_header_st_p   = hdr_q;
  assign bus.search_timeout_p = tmo_q;
  assign bus.sync_errs        = errs_q;
  assign bus.corr_busy        = (state_q != IDLE);

endmodule
